// File: rtl/proc_io_pkg.sv
// ---------------------------------------------------------------------------
// proc_io_pkg
// Shared definitions for the processor input-side buffer.
//   DEFAULT_NUBITS      default data word width (matches processor word)
//   levelWidth()        bits needed to hold an occupancy of 0..depth
//   selPolicy_t         how a request with several bits set is resolved
//   ILLEGAL_SEL_POLICY  policy used by proc_in_buf
// ---------------------------------------------------------------------------
package proc_io_pkg;

    localparam int DEFAULT_NUBITS = 32;

    // Resolution of an illegal (multi-hot) read request.
    typedef enum logic {
        SEL_LOWEST_WINS = 1'b0,
        SEL_REJECT      = 1'b1
    } selPolicy_t;

    localparam selPolicy_t ILLEGAL_SEL_POLICY = SEL_LOWEST_WINS;

    // Occupancy must represent 0..depth inclusive, hence depth+1 values.
    function automatic int levelWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/io_fifo.sv
// ---------------------------------------------------------------------------
// io_fifo
// Single-clock circular FIFO holding words for one processor input port.
// The head word is presented combinationally on dout.
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous reset, active high (clears pointers and count)
//   push   in   write din at the tail (ignored when full)
//   din    in   word to write
//   pop    in   advance the head (ignored when empty)
//   dout   out  current head word (stale/undefined when empty)
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module io_fifo
    import proc_io_pkg::*;
#(
    parameter int NUBITS = DEFAULT_NUBITS,
    parameter int DEPTH  = 4,
    parameter int CW     = levelWidth(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [NUBITS-1:0] din,
    input  logic              pop,
    output logic [NUBITS-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    localparam int PW = $clog2(DEPTH);

    logic [NUBITS-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic              w_doPush;
    logic              w_doPop;

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_head];

    // Guard against callers that do not qualify push/pop with full/empty.
    assign w_doPush = push & ~full;
    assign w_doPop  = pop & ~empty;

    // Storage carries no reset; contents behind an empty FIFO are never read.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_tail] <= din;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_doPop) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/proc_in_buf.sv
// ---------------------------------------------------------------------------
// proc_in_buf
// Input-side buffer for the soft processor's io_in port. One io_fifo per
// processor input port; the processor's one-hot req_in selects which FIFO's
// head word appears on io_in, and that FIFO pops on the same clock edge.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous reset, active high
//   src_data   in   producer words, port k at [k*NUBITS +: NUBITS]
//   src_valid  in   producer k offers a word
//   src_ready  out  FIFO k accepts a word this cycle (!full & !rst)
//   req_in     in   processor read request, one-hot (lowest index wins)
//   io_in      out  head word of the selected FIFO, 0 if empty or no request
//   level      out  occupancy of FIFO k at [k*CW +: CW]
//   uflow      out  sticky: port k was read while empty
//   uflow_cnt  out  (only with PROC_IN_BUF_UFLOW_CNT_EN) per-port 8-bit
//                   saturating count of underflow reads
// Configuration macro: PROC_IN_BUF_UFLOW_CNT_EN
// ---------------------------------------------------------------------------
module proc_in_buf
    import proc_io_pkg::*;
#(
    parameter int NUBITS = DEFAULT_NUBITS,
    parameter int NUIOIN = 2,
    parameter int DEPTH  = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUIOIN*NUBITS-1:0]           src_data,
    input  logic [NUIOIN-1:0]                  src_valid,
    output logic [NUIOIN-1:0]                  src_ready,
    input  logic [NUIOIN-1:0]                  req_in,
    output logic [NUBITS-1:0]                  io_in,
    output logic [NUIOIN*levelWidth(DEPTH)-1:0] level,
`ifdef PROC_IN_BUF_UFLOW_CNT_EN
    output logic [NUIOIN*8-1:0]                uflow_cnt,
`endif
    output logic [NUIOIN-1:0]                  uflow
);

    localparam int CW = levelWidth(DEPTH);

    logic [NUBITS-1:0] w_dout  [NUIOIN];
    logic [CW-1:0]     w_count [NUIOIN];
    logic [NUIOIN-1:0] w_full;
    logic [NUIOIN-1:0] w_empty;
    logic [NUIOIN-1:0] w_lowestOh;
    logic [NUIOIN-1:0] w_selOh;
    logic              w_multiHot;
    logic [NUIOIN-1:0] r_uflow;

    // x & -x isolates the lowest set bit, giving the priority select directly.
    assign w_lowestOh = req_in & (~req_in + NUIOIN'(1));
    assign w_multiHot = |(req_in & ~w_lowestOh);
    assign w_selOh    = ((ILLEGAL_SEL_POLICY == SEL_REJECT) && w_multiHot)
                        ? '0 : w_lowestOh;

    genvar k;
    generate
        for (k = 0; k < NUIOIN; k++) begin : g_fifo
            logic w_push;
            logic w_pop;

            // A full FIFO refuses even when it is popped in the same cycle.
            assign src_ready[k] = ~w_full[k] & ~rst;
            assign w_push       = src_valid[k] & src_ready[k];
            assign w_pop        = w_selOh[k] & ~w_empty[k];
            assign level[k*CW +: CW] = w_count[k];

            io_fifo #(
                .NUBITS (NUBITS),
                .DEPTH  (DEPTH),
                .CW     (CW)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (w_push),
                .din   (src_data[k*NUBITS +: NUBITS]),
                .pop   (w_pop),
                .dout  (w_dout[k]),
                .full  (w_full[k]),
                .empty (w_empty[k]),
                .count (w_count[k])
            );
        end
    endgenerate

    // No bypass: an empty FIFO yields 0 even if a word is being pushed now.
    always_comb begin
        io_in = '0;
        for (int i = 0; i < NUIOIN; i++) begin
            if (w_selOh[i] && !w_empty[i]) begin
                io_in = w_dout[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_uflow <= '0;
        end else begin
            r_uflow <= r_uflow | (w_selOh & w_empty);
        end
    end

    assign uflow = r_uflow;

`ifdef PROC_IN_BUF_UFLOW_CNT_EN
    logic [7:0] r_uflowCnt [NUIOIN];

    // Counters saturate at 255 rather than wrapping back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUIOIN; i++) begin
                r_uflowCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUIOIN; i++) begin
                if (w_selOh[i] && w_empty[i] && (r_uflowCnt[i] != 8'hFF)) begin
                    r_uflowCnt[i] <= r_uflowCnt[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUIOIN; i++) begin
            uflow_cnt[i*8 +: 8] = r_uflowCnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_proc_in_buf.sv
// ---------------------------------------------------------------------------
// tb_proc_in_buf
// Self-checking bench for proc_in_buf (NUBITS=32, NUIOIN=2, DEPTH=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge; the reference model advances on the rising edge.
// ---------------------------------------------------------------------------
module tb_proc_in_buf;

    localparam int NUBITS = 32;
    localparam int NUIOIN = 2;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH + 1);

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUIOIN*NUBITS-1:0] src_data = '0;
    logic [NUIOIN-1:0]        src_valid = '0;
    logic [NUIOIN-1:0]        src_ready;
    logic [NUIOIN-1:0]        req_in = '0;
    logic [NUBITS-1:0]        io_in;
    logic [NUIOIN*CW-1:0]     level;
    logic [NUIOIN-1:0]        uflow;
`ifdef PROC_IN_BUF_UFLOW_CNT_EN
    logic [NUIOIN*8-1:0]      uflow_cnt;
`endif

    proc_in_buf #(
        .NUBITS (NUBITS),
        .NUIOIN (NUIOIN),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .req_in    (req_in),
        .io_in     (io_in),
        .level     (level),
`ifdef PROC_IN_BUF_UFLOW_CNT_EN
        .uflow_cnt (uflow_cnt),
`endif
        .uflow     (uflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: one queue per port plus sticky flags and counters.
    logic [NUBITS-1:0] mq [NUIOIN][$];
    logic [NUIOIN-1:0] mReady;
    logic [NUIOIN-1:0] mUflow;
    int                mCnt [NUIOIN];
    logic [NUBITS-1:0] mIo;
    int                mSel;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  req;
        logic [31:0] expIo;
        logic [1:0]  expReady;
        int          expLvl0;
        int          expLvl1;
        logic [1:0]  expUflow;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic [1:0] v, input logic [31:0] d0,
                                input logic [31:0] d1, input logic [1:0] r,
                                input logic [31:0] eio, input logic [1:0] erdy,
                                input int l0, input int l1, input logic [1:0] euf);
        vec_t t;
        t.valid = v; t.d0 = d0; t.d1 = d1; t.req = r;
        t.expIo = eio; t.expReady = erdy; t.expLvl0 = l0; t.expLvl1 = l1;
        t.expUflow = euf;
        return t;
    endfunction

    task automatic checkVal(input string name, input logic [63:0] act,
                            input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic void modelReset();
        for (int k = 0; k < NUIOIN; k++) begin
            mq[k].delete();
            mCnt[k] = 0;
        end
        mUflow = '0;
    endfunction

    // Derive this cycle's expected combinational outputs from model state.
    function automatic void modelExpect();
        for (int k = 0; k < NUIOIN; k++) begin
            mReady[k] = (mq[k].size() < DEPTH) && !rst;
        end
        mSel = -1;
        for (int k = NUIOIN - 1; k >= 0; k--) begin
            if (req_in[k]) mSel = k;
        end
        mIo = '0;
        if (mSel >= 0 && mq[mSel].size() > 0) mIo = mq[mSel][0];
    endfunction

    function automatic void modelUpdate();
        if (rst) return;
        if (mSel >= 0) begin
            if (mq[mSel].size() > 0) begin
                void'(mq[mSel].pop_front());
            end else begin
                mUflow[mSel] = 1'b1;
                if (mCnt[mSel] < 255) mCnt[mSel]++;
            end
        end
        for (int k = 0; k < NUIOIN; k++) begin
            if (src_valid[k] && mReady[k]) mq[k].push_back(src_data[k*NUBITS +: NUBITS]);
        end
    endfunction

    task automatic applyStimulus(input logic r, input logic [1:0] v,
                                 input logic [31:0] d0, input logic [31:0] d1,
                                 input logic [1:0] req);
        rst       = r;
        src_valid = v;
        src_data  = {d1, d0};
        req_in    = req;
        if (r) modelReset();
        modelExpect();
    endtask

    task automatic checkOutput(input string name);
        checkVal({name, ".src_ready"}, 64'(src_ready), 64'(mReady));
        checkVal({name, ".io_in"}, 64'(io_in), 64'(mIo));
        for (int k = 0; k < NUIOIN; k++) begin
            checkVal($sformatf("%s.level%0d", name, k), 64'(level[k*CW +: CW]),
                     64'(mq[k].size()));
`ifdef PROC_IN_BUF_UFLOW_CNT_EN
            checkVal($sformatf("%s.uflow_cnt%0d", name, k), 64'(uflow_cnt[k*8 +: 8]),
                     64'(mCnt[k]));
`endif
        end
        checkVal({name, ".uflow"}, 64'(uflow), 64'(mUflow));
    endtask

    task automatic finishCycle();
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    initial begin
        logic [1:0] rv;
        logic [1:0] rr;

        modelReset();
        @(posedge clk);
        #1;

        // Reset state
        applyStimulus(1'b1, 2'b11, 32'hDEAD, 32'hBEEF, 2'b01);
        @(negedge clk);
        checkOutput("reset");
        checkVal("reset.src_ready_low", 64'(src_ready), 64'(2'b00));
        finishCycle();

        // Directed table: valid, d0, d1, req, io, ready, lvl0, lvl1, uflow
        vecs.push_back(mk(2'b01, 32'h11, 0, 2'b00, 0,     2'b11, 0, 0, 2'b00));
        vecs.push_back(mk(2'b01, 32'h22, 0, 2'b00, 0,     2'b11, 1, 0, 2'b00));
        vecs.push_back(mk(2'b00, 0, 0,      2'b00, 0,     2'b11, 2, 0, 2'b00));
        vecs.push_back(mk(2'b00, 0, 0,      2'b01, 32'h11, 2'b11, 2, 0, 2'b00));
        vecs.push_back(mk(2'b00, 0, 0,      2'b01, 32'h22, 2'b11, 1, 0, 2'b00));
        vecs.push_back(mk(2'b00, 0, 0,      2'b00, 0,     2'b11, 0, 0, 2'b00));
        vecs.push_back(mk(2'b10, 0, 32'hA1, 2'b00, 0,     2'b11, 0, 0, 2'b00));
        vecs.push_back(mk(2'b10, 0, 32'hA2, 2'b00, 0,     2'b11, 0, 1, 2'b00));
        vecs.push_back(mk(2'b10, 0, 32'hA3, 2'b00, 0,     2'b11, 0, 2, 2'b00));
        vecs.push_back(mk(2'b10, 0, 32'hA4, 2'b00, 0,     2'b11, 0, 3, 2'b00));
        vecs.push_back(mk(2'b10, 0, 32'hA5, 2'b00, 0,     2'b01, 0, 4, 2'b00));
        vecs.push_back(mk(2'b10, 0, 32'hA5, 2'b10, 32'hA1, 2'b01, 0, 4, 2'b00));
        vecs.push_back(mk(2'b10, 0, 32'hA5, 2'b00, 0,     2'b11, 0, 3, 2'b00));
        vecs.push_back(mk(2'b00, 0, 0,      2'b00, 0,     2'b01, 0, 4, 2'b00));
        vecs.push_back(mk(2'b00, 0, 0,      2'b10, 32'hA2, 2'b01, 0, 4, 2'b00));
        vecs.push_back(mk(2'b00, 0, 0,      2'b10, 32'hA3, 2'b11, 0, 3, 2'b00));
        vecs.push_back(mk(2'b00, 0, 0,      2'b10, 32'hA4, 2'b11, 0, 2, 2'b00));
        vecs.push_back(mk(2'b00, 0, 0,      2'b10, 32'hA5, 2'b11, 0, 1, 2'b00));
        vecs.push_back(mk(2'b10, 0, 32'h5,  2'b10, 0,     2'b11, 0, 0, 2'b00));
        vecs.push_back(mk(2'b00, 0, 0,      2'b10, 32'h5, 2'b11, 0, 1, 2'b10));
        vecs.push_back(mk(2'b00, 0, 0,      2'b00, 0,     2'b11, 0, 0, 2'b10));
        vecs.push_back(mk(2'b11, 32'hB0, 32'hC0, 2'b00, 0, 2'b11, 0, 0, 2'b10));
        vecs.push_back(mk(2'b11, 32'hB1, 32'hC1, 2'b00, 0, 2'b11, 1, 1, 2'b10));
        vecs.push_back(mk(2'b00, 0, 0,      2'b11, 32'hB0, 2'b11, 2, 2, 2'b10));
        vecs.push_back(mk(2'b00, 0, 0,      2'b00, 0,     2'b11, 1, 2, 2'b10));

        for (int i = 0; i < vecs.size(); i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            applyStimulus(1'b0, vecs[i].valid, vecs[i].d0, vecs[i].d1, vecs[i].req);
            @(negedge clk);
            checkOutput(nm);
            checkVal({nm, ".tbl_io"}, 64'(io_in), 64'(vecs[i].expIo));
            checkVal({nm, ".tbl_ready"}, 64'(src_ready), 64'(vecs[i].expReady));
            checkVal({nm, ".tbl_lvl0"}, 64'(level[0 +: CW]), 64'(vecs[i].expLvl0));
            checkVal({nm, ".tbl_lvl1"}, 64'(level[CW +: CW]), 64'(vecs[i].expLvl1));
            checkVal({nm, ".tbl_uflow"}, 64'(uflow), 64'(vecs[i].expUflow));
            finishCycle();
        end

        // Fill port0 to full, then assert reset asynchronously mid-cycle.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 2'b01, 32'hD0 + i, 0, 2'b00);
            @(negedge clk);
            checkOutput($sformatf("fill%0d", i));
            finishCycle();
        end
        applyStimulus(1'b0, 2'b00, 0, 0, 2'b00);
        #2;
        checkVal("prerst.level0", 64'(level[0 +: CW]), 64'(4));
        rst = 1'b1;
        modelReset();
        modelExpect();
        #1;
        checkVal("asyncrst.level0", 64'(level[0 +: CW]), 64'(0));
        checkVal("asyncrst.src_ready", 64'(src_ready), 64'(2'b00));
        @(negedge clk);
        checkOutput("inrst");
        finishCycle();

        // First read after reset underflows.
        applyStimulus(1'b0, 2'b00, 0, 0, 2'b01);
        @(negedge clk);
        checkOutput("postrst_read");
        checkVal("postrst.src_ready", 64'(src_ready), 64'(2'b11));
        finishCycle();
        applyStimulus(1'b0, 2'b00, 0, 0, 2'b00);
        @(negedge clk);
        checkOutput("postrst_idle");
        checkVal("postrst.uflow", 64'(uflow), 64'(2'b01));
`ifdef PROC_IN_BUF_UFLOW_CNT_EN
        checkVal("postrst.uflow_cnt0", 64'(uflow_cnt[7:0]), 64'(1));
`endif
        finishCycle();

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0, 1:    rr = 2'b00;
                2, 3:    rr = 2'b01;
                4, 5:    rr = 2'b10;
                6:       rr = 2'b11;
                default: rr = 2'($urandom_range(0, 3));
            endcase
            rv = 2'($urandom_range(0, 3));
            applyStimulus(($urandom_range(0, 63) == 0), rv, $urandom, $urandom, rr);
            @(negedge clk);
            checkOutput($sformatf("rnd%0d", i));
            finishCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net in case something above stalls.
    initial begin
        #200000;
        $display("[TB] FAIL timeout got=stalled expected=finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
